// File: rtl/motion_update_broadcast_ctrl_if.sv
// motion_update_broadcast_ctrl_if: engine request bus plus cache broadcast bus around the motion-update controller
interface motion_update_broadcast_ctrl_if #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4
);
    logic                               start;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*3*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ*3*CELL_ID_WIDTH-1:0] req_dst_cell;
    logic [NUM_REQ-1:0]                 req_done;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               motion_update_enable;
    logic [3*DATA_WIDTH-1:0]            out_data;
    logic [3*CELL_ID_WIDTH-1:0]         out_dst_cell;
    logic                               out_data_valid;
    logic                               busy;
    logic                               done;
    logic [15:0]                        particle_count;
    logic [15:0]                        drop_count;
    modport master (
        input  start, req_valid, req_data, req_dst_cell, req_done,
        output req_ready, motion_update_enable, out_data, out_dst_cell, out_data_valid,
               busy, done, particle_count, drop_count
    );
    modport slave (
        output start, req_valid, req_data, req_dst_cell, req_done,
        input  req_ready, motion_update_enable, out_data, out_dst_cell, out_data_valid,
               busy, done, particle_count, drop_count
    );
endinterface

// File: rtl/motion_update_broadcast_ctrl.sv
// motion_update_broadcast_ctrl: round-robin motion-update broadcast pass with enable cooldown before done
module motion_update_broadcast_ctrl #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int CELL_ID_WIDTH   = 4,
    parameter int CELL_X_MAX      = 4,
    parameter int CELL_Y_MAX      = 4,
    parameter int CELL_Z_MAX      = 4,
    parameter int COOLDOWN_CYCLES = 3
) (
    input logic clk,
    input logic rst,
    motion_update_broadcast_ctrl_if.master bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int DW = 3 * DATA_WIDTH;
    localparam int CW = 3 * CELL_ID_WIDTH;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RUN      = 3'd1;
    localparam logic [2:0] DRAIN    = 3'd2;
    localparam logic [2:0] COOLDOWN = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
    localparam logic [CELL_ID_WIDTH-1:0] X_MAX = CELL_ID_WIDTH'(CELL_X_MAX);
    localparam logic [CELL_ID_WIDTH-1:0] Y_MAX = CELL_ID_WIDTH'(CELL_Y_MAX);
    localparam logic [CELL_ID_WIDTH-1:0] Z_MAX = CELL_ID_WIDTH'(CELL_Z_MAX);
    localparam logic [15:0] CD_LAST = 16'(COOLDOWN_CYCLES - 1);

    logic [2:0]               state;
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            gnt_idx;
    logic [PW-1:0]            ptr_next;
    logic                     gnt_any;
    logic [NUM_REQ-1:0]       done_lat;
    logic                     all_done;
    logic [15:0]              cd_cnt;
    logic [DW-1:0]            sel_data;
    logic [CW-1:0]            sel_dst;
    logic [CELL_ID_WIDTH-1:0] sel_x;
    logic [CELL_ID_WIDTH-1:0] sel_y;
    logic [CELL_ID_WIDTH-1:0] sel_z;
    logic                     in_range;
    logic                     beat;
    logic [DW-1:0]            out_data_q;
    logic [CW-1:0]            out_dst_q;
    logic                     out_valid_q;
    logic [15:0]              part_cnt;
    logic [15:0]              drop_cnt;
    int                       j;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        j = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = j >= NUM_REQ ? j - NUM_REQ : j;
            if (state == RUN && bus.req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    assign ptr_next = gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign sel_data = bus.req_data[int'(gnt_idx)*DW +: DW];
    assign sel_dst  = bus.req_dst_cell[int'(gnt_idx)*CW +: CW];
    assign sel_x    = sel_dst[CW-1 -: CELL_ID_WIDTH];
    assign sel_y    = sel_dst[2*CELL_ID_WIDTH-1 -: CELL_ID_WIDTH];
    assign sel_z    = sel_dst[CELL_ID_WIDTH-1:0];
    assign in_range = sel_x != '0 && sel_x <= X_MAX && sel_y != '0 && sel_y <= Y_MAX &&
                      sel_z != '0 && sel_z <= Z_MAX;
    assign beat     = gnt_any && in_range;
    assign all_done = &(done_lat | bus.req_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            done_lat    <= '0;
            cd_cnt      <= '0;
            out_data_q  <= '0;
            out_dst_q   <= '0;
            out_valid_q <= 1'b0;
            part_cnt    <= '0;
            drop_cnt    <= '0;
        end else begin
            out_valid_q <= beat;
            out_data_q  <= beat ? sel_data : '0;
            out_dst_q   <= beat ? sel_dst : '0;
            case (state)
                IDLE: if (bus.start) begin
                    state    <= RUN;
                    part_cnt <= '0;
                    drop_cnt <= '0;
                end
                RUN: begin
                    done_lat <= done_lat | bus.req_done;
                    if (gnt_any) begin
                        ptr      <= ptr_next;
                        part_cnt <= part_cnt + 16'(in_range && part_cnt != 16'hFFFF);
                        drop_cnt <= drop_cnt + 16'(!in_range && drop_cnt != 16'hFFFF);
                    end else if (all_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state  <= COOLDOWN;
                    cd_cnt <= '0;
                end
                COOLDOWN: begin
                    state  <= cd_cnt == CD_LAST ? DONE : COOLDOWN;
                    cd_cnt <= cd_cnt + 16'd1;
                end
                DONE: begin
                    state    <= IDLE;
                    done_lat <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready            = gnt_any ? NUM_REQ'(1) << gnt_idx : '0;
    assign bus.motion_update_enable = state == RUN || state == DRAIN;
    assign bus.out_data             = out_data_q;
    assign bus.out_dst_cell         = out_dst_q;
    assign bus.out_data_valid       = out_valid_q;
    assign bus.busy                 = state != IDLE;
    assign bus.done                 = state == DONE;
    assign bus.particle_count       = part_cnt;
    assign bus.drop_count           = drop_cnt;
endmodule
